// File: rtl/btb_ctrl_pkg.sv
// Shared types and defaults for the BTB write-side controller.
// XLEN stands in for the system-wide PC width.
package btb_ctrl_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned BTB_ENTRIES_DEF = 16;
    localparam int unsigned QDEPTH_DEF      = 4;
    localparam int unsigned STARVE_MAX_DEF  = 4;

    typedef struct packed {
        logic [XLEN-1:0] src_pc;
        logic [XLEN-1:0] dest_pc;
    } btb_upd_t;

    typedef enum logic [0:0] {
        IDLE,
        SWEEP
    } btb_ctrl_state_t;

    function automatic btb_upd_t make_upd(input logic [XLEN-1:0] src, input logic [XLEN-1:0] dest);
        btb_upd_t u;
        u.src_pc  = src;
        u.dest_pc = dest;
        return u;
    endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Bundle of update channels, flush control and BTB write port.
// btb_stall lets the BTB write port hold off the drain so updates can queue up.
interface btb_update_ctrl_if
    import btb_ctrl_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter int unsigned QDEPTH      = QDEPTH_DEF
);

    logic                           ex_upd_valid;
    logic [XLEN-1:0]                ex_upd_src_pc;
    logic [XLEN-1:0]                ex_upd_dest_pc;
    logic                           ex_upd_ready;

    logic                           rt_upd_valid;
    logic [XLEN-1:0]                rt_upd_src_pc;
    logic [XLEN-1:0]                rt_upd_dest_pc;
    logic                           rt_upd_ready;

    logic                           flush_req;
    logic                           flush_busy;

    logic                           btb_stall;
    logic                           btb_we;
    logic [XLEN-1:0]                btb_src_pc;
    logic [XLEN-1:0]                btb_dest_pc;
    logic                           btb_inval;
    logic [$clog2(BTB_ENTRIES)-1:0] btb_inval_idx;

    logic [$clog2(QDEPTH):0]        q_count;

    modport master (
        output ex_upd_valid, ex_upd_src_pc, ex_upd_dest_pc,
        output rt_upd_valid, rt_upd_src_pc, rt_upd_dest_pc,
        output flush_req, btb_stall,
        input  ex_upd_ready, rt_upd_ready, flush_busy,
        input  btb_we, btb_src_pc, btb_dest_pc, btb_inval, btb_inval_idx, q_count
    );

    modport slave (
        input  ex_upd_valid, ex_upd_src_pc, ex_upd_dest_pc,
        input  rt_upd_valid, rt_upd_src_pc, rt_upd_dest_pc,
        input  flush_req, btb_stall,
        output ex_upd_ready, rt_upd_ready, flush_busy,
        output btb_we, btb_src_pc, btb_dest_pc, btb_inval, btb_inval_idx, q_count
    );

endinterface

// File: rtl/btb_upd_queue.sv
// Coalescing FIFO of pending BTB updates: a push whose src_pc is already queued
// overwrites that entry's dest_pc in place instead of appending.
module btb_upd_queue
    import btb_ctrl_pkg::*;
#(
    parameter int unsigned QDEPTH = QDEPTH_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  btb_upd_t                push_data_i,
    input  logic                    pop_i,
    input  logic [XLEN-1:0]         match_pc_i,
    output logic                    hit_o,
    output btb_upd_t                head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(QDEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    btb_upd_t          mem_q [QDEPTH];
    btb_upd_t          mem_d [QDEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  hit_idx;
    logic [PTR_W-1:0]  ofs;
    logic [QDEPTH-1:0] occ;

    always_comb begin : match
        hit_o   = 1'b0;
        hit_idx = '0;
        ofs     = '0;
        occ     = '0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            ofs = PTR_W'(i) - head_q;
            // The head leaving this cycle cannot absorb an update; it appends instead.
            occ[i] = ({1'b0, ofs} < count_q) && !(pop_i && (ofs == '0));
            if (!hit_o && occ[i] && (mem_q[i].src_pc == match_pc_i)) begin
                hit_o   = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin : next_state
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_i) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push_i) begin
                if (hit_o) begin
                    mem_d[hit_idx].dest_pc = push_data_i.dest_pc;
                end else begin
                    mem_d[tail_q] = push_data_i;
                    tail_d        = tail_q + PTR_W'(1);
                end
            end
            count_d = count_q + CNT_W'(push_i && !hit_o) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[head_q];
    assign full_o  = (count_q == CNT_W'(QDEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: arbitrates ex/retire updates into a coalescing queue,
// drains one update per cycle to the BTB and sequences the invalidate sweep on flush.
module btb_update_ctrl
    import btb_ctrl_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter int unsigned QDEPTH      = QDEPTH_DEF,
    parameter int unsigned STARVE_MAX  = STARVE_MAX_DEF
) (
    input logic              clock,
    input logic              reset,
    btb_update_ctrl_if.slave bus
);

    localparam int unsigned      IDX_W      = $clog2(BTB_ENTRIES);
    localparam int unsigned      CNT_W      = $clog2(QDEPTH) + 1;
    localparam int unsigned      SW         = $clog2(STARVE_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BTB_ENTRIES - 1);
    localparam logic [SW-1:0]    STARVE_TOP = SW'(STARVE_MAX);

    btb_ctrl_state_t  state_q, state_d;
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             btb_we_q, btb_we_d;
    btb_upd_t         btb_upd_q, btb_upd_d;

    logic             rt_force;
    logic             sel_rt;
    logic             sel_ex;
    logic             accept_ok;
    logic             ex_gnt;
    logic             rt_gnt;
    btb_upd_t         sel_upd;
    btb_upd_t         q_head;
    logic             q_push;
    logic             q_pop;
    logic             q_hit;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;

    // ex has fixed priority; retire wins when ex is idle or it has lost STARVE_MAX times.
    always_comb begin : arbiter
        rt_force  = bus.rt_upd_valid && (starve_q == STARVE_TOP);
        sel_rt    = bus.rt_upd_valid && (!bus.ex_upd_valid || rt_force);
        sel_ex    = bus.ex_upd_valid && !sel_rt;
        sel_upd   = sel_rt ? make_upd(bus.rt_upd_src_pc, bus.rt_upd_dest_pc)
                           : make_upd(bus.ex_upd_src_pc, bus.ex_upd_dest_pc);
        accept_ok = (state_q == IDLE) && !bus.flush_req && (!q_full || q_hit);
        ex_gnt    = sel_ex && accept_ok;
        rt_gnt    = sel_rt && accept_ok;
        q_push    = ex_gnt || rt_gnt;
        q_pop     = (state_q == IDLE) && !bus.flush_req && !bus.btb_stall && !q_empty;
    end

    btb_upd_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (bus.flush_req),
        .push_i      (q_push),
        .push_data_i (sel_upd),
        .pop_i       (q_pop),
        .match_pc_i  (sel_upd.src_pc),
        .hit_o       (q_hit),
        .head_o      (q_head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    always_comb begin : dp_next
        starve_d = starve_q;
        if (rt_gnt) begin
            starve_d = '0;
        end else if (bus.rt_upd_valid && ex_gnt && (starve_q != STARVE_TOP)) begin
            starve_d = starve_q + SW'(1);
        end
        btb_we_d  = q_pop;
        btb_upd_d = q_pop ? q_head : btb_upd_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_q  <= '0;
            btb_we_q  <= 1'b0;
            btb_upd_q <= '0;
        end else begin
            starve_q  <= starve_d;
            btb_we_q  <= btb_we_d;
            btb_upd_q <= btb_upd_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // A flush in either state (re)starts the sweep at entry 0.
    always_comb begin : fsm_next
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.flush_req) begin
                    state_d     = SWEEP;
                    sweep_idx_d = '0;
                end
            end
            SWEEP: begin
                if (bus.flush_req) begin
                    sweep_idx_d = '0;
                end else if (sweep_idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    sweep_idx_d = sweep_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin : fsm_out
        bus.ex_upd_ready  = ex_gnt;
        bus.rt_upd_ready  = rt_gnt;
        bus.flush_busy    = (state_q == SWEEP);
        bus.btb_inval     = (state_q == SWEEP);
        bus.btb_inval_idx = sweep_idx_q;
        bus.btb_we        = btb_we_q;
        bus.btb_src_pc    = btb_upd_q.src_pc;
        bus.btb_dest_pc   = btb_upd_q.dest_pc;
        bus.q_count       = q_count;
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: queue-based reference model plus a write scoreboard,
// directed scenarios followed by randomized traffic.
module tb_btb_update_ctrl;
    import btb_ctrl_pkg::*;

    localparam int unsigned NENT = 16;
    localparam int unsigned QD   = 4;
    localparam int unsigned SMAX = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    btb_update_ctrl_if #(.BTB_ENTRIES(NENT), .QDEPTH(QD)) bus ();

    btb_update_ctrl #(
        .BTB_ENTRIES (NENT),
        .QDEPTH      (QD),
        .STARVE_MAX  (SMAX)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] src;
        logic [31:0] dest;
    } upd_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dest;
        int          cyc;
    } wr_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    upd_t mq[$];
    wr_t  sb[$];
    int   starve = 0;
    int   sweep  = -1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: evaluated mid-cycle with inputs stable, then advanced to
    // the state expected after the coming rising edge.
    always @(negedge clock) begin : model_p
        bit   exv, rtv, fl, st, idle, sel_rt, sel_ex, popping, hit, can, exr, rtr;
        int   k;
        upd_t u;
        if (!reset) begin
            mq.delete();
            sb.delete();
            starve = 0;
            sweep  = -1;
            chk("rst_btb_we", bus.btb_we, 0);
            chk("rst_inval", bus.btb_inval, 0);
            chk("rst_inval_idx", bus.btb_inval_idx, 0);
            chk("rst_flush_busy", bus.flush_busy, 0);
            chk("rst_q_count", bus.q_count, 0);
            chk("rst_ex_ready", bus.ex_upd_ready, 0);
            chk("rst_rt_ready", bus.rt_upd_ready, 0);
        end else begin
            chk("q_count", bus.q_count, mq.size());
            chk("inval", bus.btb_inval, sweep >= 0);
            chk("flush_busy", bus.flush_busy, sweep >= 0);
            if (sweep >= 0) chk("inval_idx", bus.btb_inval_idx, sweep);
            exv     = bus.ex_upd_valid;
            rtv     = bus.rt_upd_valid;
            fl      = bus.flush_req;
            st      = bus.btb_stall;
            idle    = (sweep < 0);
            sel_rt  = rtv && (!exv || starve == SMAX);
            sel_ex  = exv && !sel_rt;
            u.src   = sel_rt ? bus.rt_upd_src_pc : bus.ex_upd_src_pc;
            u.dest  = sel_rt ? bus.rt_upd_dest_pc : bus.ex_upd_dest_pc;
            popping = idle && !fl && !st && (mq.size() > 0);
            k = -1;
            for (int i = 0; i < mq.size(); i++)
                if (k < 0 && mq[i].src == u.src && !(i == 0 && popping)) k = i;
            hit = (k >= 0);
            can = idle && !fl && (mq.size() < QD || hit);
            exr = sel_ex && can;
            rtr = sel_rt && can;
            chk("ex_ready", bus.ex_upd_ready, exr);
            chk("rt_ready", bus.rt_upd_ready, rtr);
            if (rtr) starve = 0;
            else if (rtv && exr && starve < SMAX) starve++;
            if (exr || rtr) begin
                if (hit) mq[k].dest = u.dest;
                else mq.push_back(u);
            end
            if (popping) begin
                sb.push_back('{src: mq[0].src, dest: mq[0].dest, cyc: cyc + 1});
                void'(mq.pop_front());
            end
            if (fl) begin
                mq.delete();
                sweep = 0;
            end else if (sweep >= 0) begin
                sweep = (sweep == NENT - 1) ? -1 : sweep + 1;
            end
        end
    end

    always @(negedge clock) begin : monitor_p
        wr_t e;
        if (reset) begin
            if (bus.btb_we) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL btb_we_unexpected: got write %0h->%0h, expected none (cycle %0d)",
                             bus.btb_src_pc, bus.btb_dest_pc, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("wr_src", bus.btb_src_pc, e.src);
                    chk("wr_dest", bus.btb_dest_pc, e.dest);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL btb_we_missing: got no write, expected %0h->%0h (cycle %0d)",
                         sb[0].src, sb[0].dest, cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic step(input bit exv, input logic [31:0] exs, input logic [31:0] exd,
                        input bit rtv, input logic [31:0] rts, input logic [31:0] rtd,
                        input bit fl, input bit st);
        @(posedge clock);
        #1;
        bus.ex_upd_valid   = exv;
        bus.ex_upd_src_pc  = exs;
        bus.ex_upd_dest_pc = exd;
        bus.rt_upd_valid   = rtv;
        bus.rt_upd_src_pc  = rts;
        bus.rt_upd_dest_pc = rtd;
        bus.flush_req      = fl;
        bus.btb_stall      = st;
        @(negedge clock);
    endtask

    task automatic idle_step(input bit st);
        step(0, 0, 0, 0, 0, 0, 0, st);
    endtask

    initial begin
        bus.ex_upd_valid   = 0;
        bus.ex_upd_src_pc  = 0;
        bus.ex_upd_dest_pc = 0;
        bus.rt_upd_valid   = 0;
        bus.rt_upd_src_pc  = 0;
        bus.rt_upd_dest_pc = 0;
        bus.flush_req      = 0;
        bus.btb_stall      = 0;
        reset              = 0;
        repeat (10) @(posedge clock);
        #1 reset = 1;
        repeat (3) idle_step(0);

        // Single ex update: accepted, queued one cycle, then written.
        step(1, 32'h100, 32'h200, 0, 0, 0, 0, 0);
        chk("single_ex_ready", bus.ex_upd_ready, 1);
        idle_step(0);
        chk("single_we_low", bus.btb_we, 0);
        chk("single_qcount", bus.q_count, 1);
        idle_step(0);
        chk("single_we", bus.btb_we, 1);
        chk("single_src", bus.btb_src_pc, 32'h100);
        chk("single_dest", bus.btb_dest_pc, 32'h200);
        chk("single_qcount_0", bus.q_count, 0);
        repeat (3) idle_step(0);

        // Both sources valid: ex wins until retire has lost STARVE_MAX times.
        for (int c = 0; c < 6; c++) begin
            step(1, 32'h2000 + c * 4, 32'h2800 + c * 4, 1, 32'h3000 + c * 4, 32'h3800 + c * 4, 0, 0);
            chk("arb_ex_ready", bus.ex_upd_ready, c != 4);
            chk("arb_rt_ready", bus.rt_upd_ready, c == 4);
        end
        repeat (4) idle_step(0);

        // Fill with drain stalled, reject when full, coalesce into the full queue.
        for (int c = 0; c < 4; c++) begin
            step(1, 32'h100 + c * 32'h10, 32'h1000 + c, 0, 0, 0, 0, 1);
            chk("fill_ready", bus.ex_upd_ready, 1);
        end
        step(1, 32'h500, 32'h5000, 0, 0, 0, 0, 1);
        chk("full_ready", bus.ex_upd_ready, 0);
        chk("full_qcount", bus.q_count, 4);
        step(1, 32'h100, 32'h300, 0, 0, 0, 0, 1);
        chk("coalesce_ready", bus.ex_upd_ready, 1);
        idle_step(1);
        chk("coalesce_qcount", bus.q_count, 4);
        idle_step(0);
        idle_step(0);
        chk("coalesce_we", bus.btb_we, 1);
        chk("coalesce_src", bus.btb_src_pc, 32'h100);
        chk("coalesce_dest", bus.btb_dest_pc, 32'h300);
        repeat (6) idle_step(0);

        // Flush with three queued updates: dropped, then full invalidate sweep.
        for (int c = 0; c < 3; c++) step(1, 32'h600 + c * 4, 32'h6000 + c, 0, 0, 0, 0, 1);
        idle_step(1);
        chk("flush_pre_qcount", bus.q_count, 3);
        step(1, 32'h700, 32'h7000, 0, 0, 0, 1, 1);
        chk("flush_cycle_ready", bus.ex_upd_ready, 0);
        for (int i = 0; i < int'(NENT); i++) begin
            step(1, 32'h700 + i * 4, 32'h7000, 1, 32'h800 + i * 4, 32'h8000, 0, 0);
            chk("sweep_inval", bus.btb_inval, 1);
            chk("sweep_idx", bus.btb_inval_idx, i);
            chk("sweep_ex_ready", bus.ex_upd_ready, 0);
            chk("sweep_rt_ready", bus.rt_upd_ready, 0);
            chk("sweep_we", bus.btb_we, 0);
        end
        idle_step(0);
        chk("post_sweep_inval", bus.btb_inval, 0);
        chk("post_sweep_busy", bus.flush_busy, 0);
        chk("post_sweep_qcount", bus.q_count, 0);

        // Restart mid-sweep, then abort it with an asynchronous reset.
        step(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            idle_step(0);
            chk("mid_idx", bus.btb_inval_idx, i);
        end
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("mid_idx5", bus.btb_inval_idx, 5);
        idle_step(0);
        chk("restart_inval", bus.btb_inval, 1);
        chk("restart_idx0", bus.btb_inval_idx, 0);
        idle_step(0);
        chk("restart_idx1", bus.btb_inval_idx, 1);
        @(posedge clock);
        #3 reset = 0;
        #1;
        chk("async_rst_inval", bus.btb_inval, 0);
        chk("async_rst_busy", bus.flush_busy, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1;
        repeat (2) idle_step(0);

        // Randomized traffic over a small PC pool so coalescing happens often.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 99) < 60, 32'h4000 + 4 * $urandom_range(0, 5), $urandom,
                 $urandom_range(0, 99) < 50, 32'h4000 + 4 * $urandom_range(0, 5), $urandom,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 40);
        end
        repeat (30) idle_step(0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
